// File: rtl/psc_sequencer_if.sv
// Word-in / byte-sequencing bundle between an upstream word source and psc_sequencer.
// master drives words and abort; slave (the sequencer) drives converter control and byte markers.
interface psc_sequencer_if;
  logic        abort;
  logic        word_valid;
  logic [31:0] word_in;
  logic        word_ready;
  logic        psc_load;
  logic [31:0] psc_word;
  logic        byte_valid;
  logic [1:0]  byte_idx;
  logic        byte_first;
  logic        byte_last;
  logic        busy;

  modport master (
    output abort, word_valid, word_in,
    input  word_ready, psc_load, psc_word, byte_valid, byte_idx, byte_first, byte_last, busy
  );

  modport slave (
    input  abort, word_valid, word_in,
    output word_ready, psc_load, psc_word, byte_valid, byte_idx, byte_first, byte_last, busy
  );
endinterface

// File: rtl/psc_sequencer.sv
// Sequences a parallel-to-serial converter: loads one 32-bit word, then shifts three more bytes out MSB-first.
// One word per 4 cycles; word_ready only in IDLE, so upstream stalls during SHIFT; abort/rst drop pending bytes.
module psc_sequencer #(
  parameter int unsigned WORDS_PER_BLOCK = 4
) (
  input  logic      clk,
  input  logic      rst,
  psc_sequencer_if.slave seq
);

  localparam int unsigned WW = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
  localparam logic [WW-1:0] WLAST = WW'(WORDS_PER_BLOCK - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;

  logic        live;
  logic        accept;
  logic        shifting;
  logic        word_ready;
  logic        byte_valid;
  logic [1:0]  byte_idx;

  // Outputs are masked by rst/abort in the same cycle, not just after the clock edge.
  always_comb begin
    live       = ~rst & ~seq.abort;
    word_ready = live & (state_q == IDLE);
    accept     = word_ready & seq.word_valid;
    shifting   = live & (state_q == SHIFT);
    byte_valid = accept | shifting;
    byte_idx   = shifting ? cnt_q : 2'd0;
  end

  assign seq.word_ready = word_ready;
  assign seq.psc_load   = accept;
  assign seq.psc_word   = accept ? seq.word_in : 32'd0;
  assign seq.byte_valid = byte_valid;
  assign seq.byte_idx   = byte_idx;
  assign seq.byte_first = byte_valid & (byte_idx == 2'd0) & (wcnt_q == '0);
  assign seq.byte_last  = byte_valid & (byte_idx == 2'd3) & (wcnt_q == WLAST);
  assign seq.busy       = ~rst & (state_q == SHIFT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    if (seq.abort) begin
      state_d = IDLE;
      cnt_d   = 2'd0;
      wcnt_d  = '0;
    end else if (accept) begin
      state_d = SHIFT;
      cnt_d   = 2'd1;
    end else if (state_q == SHIFT) begin
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        state_d = IDLE;
        // wcnt holds across IDLE gaps so a block may be delivered in pieces.
        wcnt_d  = (wcnt_q == WLAST) ? '0 : wcnt_q + WW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule

// File: doc/psc_sequencer.md
PSC_SEQUENCER -- requirements
Module: psc_sequencer

Interface
REQ-001 Parameter WORDS_PER_BLOCK, default 4, sets the number of 32-bit words per cipher block (16 bytes); legal range is 1..16.
REQ-002 Port clk, input, 1 bit, the single clock, rising edge.
REQ-003 Port rst, input, 1 bit, synchronous active-high reset.
REQ-004 Port abort, input, 1 bit, synchronous sequence cancel.
REQ-005 Port word_valid, input, 1 bit, upstream word available.
REQ-006 Port word_in, input, 32 bits; the highest byte is serialised first.
REQ-007 Port word_ready, output, 1 bit; the sequencer accepts word_in this cycle.
REQ-008 Port psc_load, output, 1 bit, drives the converter parallel_load (1 = load, 0 = shift).
REQ-009 Port psc_word, output, 32 bits, drives the converter parallel_data_in.
REQ-010 Port byte_valid, output, 1 bit; the converter data_out carries a valid byte this cycle.
REQ-011 Port byte_idx, output, 2 bits, position of the current byte in its word (0 = word_in[31:24]).
REQ-012 Port byte_first, output, 1 bit, marks the first byte of a block.
REQ-013 Port byte_last, output, 1 bit, marks the last byte of a block.
REQ-014 Port busy, output, 1 bit; high while the sequencer is in the SHIFT state.

Function
REQ-015 States: IDLE and SHIFT; 2-bit shift counter cnt; word counter wcnt of width clog2(WORDS_PER_BLOCK), minimum 1 bit.
REQ-016 Ready: word_ready = (state==IDLE) & ~rst & ~abort, combinational.
REQ-017 Accept: accept = word_valid & word_ready.
REQ-018 Accept cycle outputs, combinational: psc_load=1, psc_word=word_in, byte_valid=1, byte_idx=0.
REQ-019 Accept transition: state to SHIFT, cnt to 1.
REQ-020 Non-accept cycles: psc_load=0 and psc_word=0.
REQ-021 SHIFT with cnt=k (k=1,2,3): byte_valid=1, byte_idx=k, word_ready=0; cnt increments.
REQ-022 SHIFT exit: when cnt=3 the state returns to IDLE next cycle.
REQ-023 Byte order: across cycles 0..3 after accept, the converter output sequence is word_in[31:24], [23:16], [15:8], [7:0].
REQ-024 Word rate: throughput is 1 word per 4 cycles; back-to-back words continue without bubbles when word_valid is held high.
REQ-025 IDLE without accept: byte_valid=0, byte_idx=0, byte_first=0, byte_last=0.
REQ-026 Block marker, first: byte_first=1 when byte_valid & byte_idx==0 & wcnt==0.
REQ-027 Block marker, last: byte_last=1 when byte_valid & byte_idx==3 & wcnt==WORDS_PER_BLOCK-1.
REQ-028 Word count: wcnt increments on the byte_idx==3 cycle and wraps to 0 after WORDS_PER_BLOCK-1; with WORDS_PER_BLOCK=1, every word raises both byte_first and byte_last.
REQ-029 word_valid low in IDLE: no state change; wcnt holds, so blocks may span idle gaps.
REQ-030 Abort: next cycle state=IDLE, cnt=0, wcnt=0.
REQ-031 Abort cycle outputs: word_ready=0, psc_load=0, byte_valid=0, byte_first=0, byte_last=0, regardless of state or word_valid.
REQ-032 Abort mid-word: the remaining bytes of the word are dropped; no byte_valid is asserted for them.
REQ-033 Input-change tolerance: word_in and word_valid may change freely while word_ready=0; the sequencer samples them only on accept.

Reset
REQ-034 While rst=1: word_ready=0, psc_load=0, psc_word=0, byte_valid=0, byte_idx=0, byte_first=0, byte_last=0, busy=0.
REQ-035 Register reset values: state=IDLE, cnt=0, wcnt=0, all applied on the clock edge.
REQ-036 Priority: rst takes precedence over abort, and abort takes precedence over accept.
REQ-037 Reset mid-word: the same drop behaviour as REQ-032 applies.
REQ-038 After reset: the first cycle with rst=0 and word_valid=1 is an accept.

Verification
REQ-039 Scenario, single word: word_in=32'hA1B2C3D4 after reset, WORDS_PER_BLOCK=4 -> psc_load only in cycle 0; bytes A1,B2,C3,D4 with idx 0..3; byte_first in cycle 0; byte_last never.
REQ-040 Scenario, full block: 4 words with word_valid held high -> 16 consecutive byte_valid cycles; byte_first on byte 0 only; byte_last on byte 15 only; wcnt back to 0; word_ready high every 4th cycle.
REQ-041 Scenario, gapped block: 2 words, 10 idle cycles, then 2 words -> byte_last on the 16th valid byte; byte_first not reasserted after the gap.
REQ-042 Scenario, abort mid-word: abort at cnt=2 of word 1 -> no bytes for idx 2-3; next word gives byte_first=1 with bytes in correct order.
REQ-043 Scenario, reset mid-word: rst for one cycle at cnt=1 with word_valid high -> all outputs 0 that cycle; accept on the following cycle; wcnt=0.
REQ-044 Scenario, single-word blocks: WORDS_PER_BLOCK=1 with 3 back-to-back words -> byte_first and byte_last on every word; byte_valid continuous for 12 cycles.
